// File: rtl/axi_pkg.sv
// Shared definitions for the AXI receive-side blocks: default geometry and
// pointer-width helper used to size FIFO addresses.
package axi_pkg;

    localparam int RX_WIDTH_DEF = 8;
    localparam int RX_DEPTH_DEF = 4;
    localparam int RX_AFULL_DEF = 3;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// The array holds no reset; occupancy is tracked by the owner of the pointers.
module rx_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_rx_fifo_channel.sv
// Buffered receive side of one AXI channel: VALID/READY beats go into a small
// FIFO and are presented first-word-fall-through to the upper module.
module axi_rx_fifo_channel
    import axi_pkg::*;
#(
    parameter int WIDTH    = RX_WIDTH_DEF,
    parameter int DEPTH    = RX_DEPTH_DEF,
    parameter int AFULL_TH = RX_AFULL_DEF
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       VALID,
    output logic                       READY,
    input  logic [WIDTH-1:0]           xDATA,
    input  logic                       xLAST,
    output logic [WIDTH-1:0]           rx_data,
    output logic                       rx_last,
    output logic                       rx_new_data,
    input  logic                       rx_pop,
    output logic [$clog2(DEPTH):0]     rx_count,
    output logic                       rx_almost_full
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } rx_beat_t;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ready_q,  ready_d;
    logic          push, pop;
    rx_beat_t      wbeat, rbeat;

    always_comb begin
        push     = VALID & ready_q;
        pop      = rx_pop & (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // READY is a function of next occupancy only, so it never combinationally follows VALID.
        ready_d = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    assign wbeat = {xLAST, xDATA};

    rx_fifo_mem #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (ACLK),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wbeat),
        .raddr (rd_ptr_q),
        .rdata (rbeat)
    );

    assign READY          = ready_q;
    assign rx_data        = rbeat.data;
    assign rx_last        = rbeat.last;
    assign rx_new_data    = (count_q != '0);
    assign rx_count       = count_q;
    assign rx_almost_full = (count_q >= CW'(AFULL_TH));

endmodule

// File: tb/tb_axi_rx_fifo_channel.sv
// Self-checking bench for axi_rx_fifo_channel (WIDTH=8, DEPTH=4, AFULL_TH=3):
// a queue scoreboard tracks accepted beats and checks every pop in order.
module tb_axi_rx_fifo_channel;

    logic       ACLK;
    logic       ARESET;
    logic       VALID;
    logic       READY;
    logic [7:0] xDATA;
    logic       xLAST;
    logic [7:0] rx_data;
    logic       rx_last;
    logic       rx_new_data;
    logic       rx_pop;
    logic [2:0] rx_count;
    logic       rx_almost_full;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q [$];
    logic [8:0] sb_e;

    axi_rx_fifo_channel #(
        .WIDTH    (8),
        .DEPTH    (4),
        .AFULL_TH (3)
    ) dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .VALID          (VALID),
        .READY          (READY),
        .xDATA          (xDATA),
        .xLAST          (xLAST),
        .rx_data        (rx_data),
        .rx_last        (rx_last),
        .rx_new_data    (rx_new_data),
        .rx_pop         (rx_pop),
        .rx_count       (rx_count),
        .rx_almost_full (rx_almost_full)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Scoreboard: pops are checked against the head before this cycle's push is queued.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (rx_pop && rx_new_data) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_pop: got %h, required no beat pending", {rx_last, rx_data});
                end else begin
                    sb_e = exp_q.pop_front();
                    if ({rx_last, rx_data} !== sb_e) begin
                        bad++;
                        $display("FAIL sb_pop: got %h, required %h", {rx_last, rx_data}, sb_e);
                    end
                end
            end
            if (VALID && READY) begin
                exp_q.push_back({xLAST, xDATA});
            end
        end
    end

    task automatic test_reset();
        ARESET = 1'b1;
        VALID  = 1'b1;
        xDATA  = 8'h55;
        xLAST  = 1'b0;
        rx_pop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge ACLK); #1;
            total++;
            if ({READY, rx_new_data, rx_count, rx_almost_full} !== 6'b0) begin
                bad++;
                $display("FAIL reset_hold: got rdy=%b nd=%b cnt=%0d af=%b, required all 0",
                         READY, rx_new_data, rx_count, rx_almost_full);
            end
        end
        ARESET = 1'b0;
        VALID  = 1'b0;
        total++;
        if (READY !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: READY=%b, required 0", READY);
        end
        @(posedge ACLK); #1;
        total++;
        if (READY !== 1'b1 || rx_count !== 3'd0) begin
            bad++;
            $display("FAIL reset_ready: READY=%b cnt=%0d, required 1 and 0", READY, rx_count);
        end
    endtask

    task automatic test_stream();
        logic [7:0] v [3];
        v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33;
        rx_pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            VALID = 1'b1;
            xDATA = v[i];
            xLAST = 1'b0;
            @(posedge ACLK); #1;
            total++;
            if (READY !== 1'b1 || rx_new_data !== 1'b1 || rx_data !== v[i] || rx_count !== 3'd1) begin
                bad++;
                $display("FAIL stream_%0d: rdy=%b nd=%b data=%h cnt=%0d, required 1 1 %h 1",
                         i, READY, rx_new_data, rx_data, rx_count, v[i]);
            end
        end
        VALID = 1'b0;
        @(posedge ACLK); #1;
        rx_pop = 1'b0;
        total++;
        if (rx_count !== 3'd0 || rx_new_data !== 1'b0) begin
            bad++;
            $display("FAIL stream_drain: cnt=%0d nd=%b, required 0 0", rx_count, rx_new_data);
        end
    endtask

    task automatic test_fill_and_full_pop();
        int   idx  = 0;
        int   mcnt = 0;
        logic r;
        rx_pop = 1'b0;
        VALID  = 1'b1;
        xLAST  = 1'b0;
        xDATA  = 8'hA0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            r = READY;
            @(posedge ACLK); #1;
            if (r) begin
                idx++;
                mcnt++;
            end
            xDATA = 8'hA0 + 8'(idx);
            total++;
            if (rx_count !== 3'(mcnt) || rx_almost_full !== (mcnt >= 3)) begin
                bad++;
                $display("FAIL fill_%0d: cnt=%0d af=%b, required %0d %b",
                         i, rx_count, rx_almost_full, mcnt, (mcnt >= 3));
            end
        end
        total++;
        if (idx != 4 || READY !== 1'b0) begin
            bad++;
            $display("FAIL fill_full: accepted=%0d READY=%b, required 4 0", idx, READY);
        end
        // Two rounds: pop once at full, then the stalled beat lands one cycle later.
        for (int k = 0; k < 2; k++) begin
            rx_pop = 1'b1;
            @(posedge ACLK); #1;
            rx_pop = 1'b0;
            total++;
            if (rx_count !== 3'd3 || READY !== 1'b1) begin
                bad++;
                $display("FAIL fullpop_%0d_a: cnt=%0d READY=%b, required 3 1", k, rx_count, READY);
            end
            @(posedge ACLK); #1;
            xDATA = 8'hA5;
            if (k == 1) VALID = 1'b0;
            total++;
            if (rx_count !== 3'd4 || READY !== 1'b0) begin
                bad++;
                $display("FAIL fullpop_%0d_b: cnt=%0d READY=%b, required 4 0", k, rx_count, READY);
            end
        end
        rx_pop = 1'b1;
        for (int k = 0; k < 20 && rx_new_data; k++) begin
            @(posedge ACLK); #1;
        end
        rx_pop = 1'b0;
        total++;
        if (rx_count !== 3'd0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL fill_drain: cnt=%0d pending=%0d, required 0 0", rx_count, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        rx_pop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            VALID = 1'b1;
            xDATA = 8'(i);
            xLAST = (i == 9);
            @(posedge ACLK); #1;
            total++;
            if (rx_data !== 8'(i) || rx_last !== (i == 9) || rx_count !== 3'd1) begin
                bad++;
                $display("FAIL wrap_%0d: data=%h last=%b cnt=%0d, required %h %b 1",
                         i, rx_data, rx_last, rx_count, 8'(i), (i == 9));
            end
        end
        VALID = 1'b0;
        xLAST = 1'b0;
        @(posedge ACLK); #1;
        rx_pop = 1'b0;
        total++;
        if (rx_count !== 3'd0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL wrap_drain: cnt=%0d pending=%0d, required 0 0", rx_count, exp_q.size());
        end
    endtask

    task automatic test_underflow_reset();
        VALID  = 1'b0;
        rx_pop = 1'b1;
        repeat (3) begin
            @(posedge ACLK); #1;
            total++;
            if (rx_count !== 3'd0 || rx_new_data !== 1'b0) begin
                bad++;
                $display("FAIL underflow: cnt=%0d nd=%b, required 0 0", rx_count, rx_new_data);
            end
        end
        rx_pop = 1'b0;
        VALID  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            xDATA = 8'hC0 + 8'(i);
            @(posedge ACLK); #1;
        end
        VALID = 1'b0;
        total++;
        if (rx_count !== 3'd3 || rx_almost_full !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: cnt=%0d af=%b, required 3 1", rx_count, rx_almost_full);
        end
        #1;
        ARESET = 1'b1;
        exp_q.delete();
        #1;
        total++;
        if (rx_count !== 3'd0 || rx_new_data !== 1'b0 || READY !== 1'b0 || rx_almost_full !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: cnt=%0d nd=%b rdy=%b af=%b, required 0 0 0 0",
                     rx_count, rx_new_data, READY, rx_almost_full);
        end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        total++;
        if (READY !== 1'b1 || rx_count !== 3'd0) begin
            bad++;
            $display("FAIL reset_recover: READY=%b cnt=%0d, required 1 0", READY, rx_count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_and_full_pop();
        test_wrap();
        test_underflow_reset();
        repeat (2) @(posedge ACLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
